multicycle_cu: RTL

- Finite-state control unit that sequences the existing CPU datapath (PC, InstructionMemory, RegFile, ALU, DataMemory) over several cycles per instruction.
- Replaces the single-cycle combinational CU. It adds PC/IR write enables, a wait-state handshake to DataMemory, a halt/fault state and a retired-instruction counter.
- Opcode and Funct come from the datapath's instruction register, which is loaded only when IRWrite=1.

---
 rtl/multicycle_cu.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// multicycle_cu: multi-cycle FSM control unit sequencing the CPU datapath over IF/ID/EXE/MEM/WB.
// Optional jal support in ID is enabled by defining MCU_JAL_EN.
module multicycle_cu #(
  parameter int unsigned COUNT_W     = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               Sign,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DB,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegDst,
  output logic               ExtSel,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               Link,
  output logic               Halted,
  output logic               Fault,
  output logic [2:0]         State,
  output logic [COUNT_W-1:0] RetireCount
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;
  localparam logic [1:0] PC_REG  = 2'b11;

  logic [2:0]         r_state;
  logic [COUNT_W-1:0] r_retire_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_fault;

  logic [2:0] w_next_state;
  logic       w_retire;
  logic       w_to_inc;
  logic       w_halt_fault;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_db;
  logic       w_reg_dst;
  logic [1:0] w_pc_src;
  logic       w_link;

  logic [2:0] w_alu_op;
  logic       w_alu_src_a;
  logic       w_alu_src_b;
  logic       w_ext_sel;
  logic       w_legal;
  logic       w_is_jr;
  logic       w_is_jal;
  logic       w_is_rtype;
  logic       w_is_j;
  logic       w_is_halt;
  logic       w_is_lw;
  logic       w_is_sw;
  logic       w_is_branch;
  logic       w_br_taken;
  logic       w_alu_hold;

  assign w_is_rtype  = (Opcode == OP_RTYPE);
  assign w_is_j      = (Opcode == OP_J);
  assign w_is_halt   = (Opcode == OP_HALT);
  assign w_is_lw     = (Opcode == OP_LW);
  assign w_is_sw     = (Opcode == OP_SW);
  assign w_is_branch = (Opcode == OP_BEQ) || (Opcode == OP_BNE) || (Opcode == OP_BLTZ);
  assign w_br_taken  = ((Opcode == OP_BEQ) &&  Zero) ||
                       ((Opcode == OP_BNE) && !Zero) ||
                       ((Opcode == OP_BLTZ) && Sign);

`ifdef MCU_JAL_EN
  assign w_is_jal = (Opcode == OP_JAL);
`else
  assign w_is_jal = 1'b0;
`endif

  // Instruction decode: ALU controls and legality from the IR fields
  always_comb begin
    w_alu_op    = ALU_ADD;
    w_alu_src_a = 1'b0;
    w_alu_src_b = 1'b0;
    w_ext_sel   = 1'b0;
    w_legal     = 1'b1;
    w_is_jr     = 1'b0;
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD: w_alu_op = ALU_ADD;
          FN_SUB: w_alu_op = ALU_SUB;
          FN_AND: w_alu_op = ALU_AND;
          FN_OR:  w_alu_op = ALU_OR;
          FN_SLT: w_alu_op = ALU_SLT;
          FN_SLL: begin
            w_alu_op    = ALU_SLL;
            w_alu_src_a = 1'b1;
          end
          FN_JR:   w_is_jr = 1'b1;
          default: w_legal = 1'b0;
        endcase
      end
      OP_BEQ, OP_BNE, OP_BLTZ: begin
        w_alu_op  = ALU_SUB;
        w_ext_sel = 1'b1;
      end
      OP_LW, OP_SW, OP_ADDIU: begin
        w_alu_op    = ALU_ADD;
        w_alu_src_b = 1'b1;
        w_ext_sel   = 1'b1;
      end
      OP_SLTI: begin
        w_alu_op    = ALU_SLT;
        w_alu_src_b = 1'b1;
        w_ext_sel   = 1'b1;
      end
      OP_ANDI: begin
        w_alu_op    = ALU_AND;
        w_alu_src_b = 1'b1;
      end
      OP_ORI: begin
        w_alu_op    = ALU_OR;
        w_alu_src_b = 1'b1;
      end
      OP_J, OP_HALT: ;
`ifdef MCU_JAL_EN
      OP_JAL: ;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    w_to_inc     = 1'b0;
    w_halt_fault = 1'b0;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_db         = 1'b0;
    w_reg_dst    = 1'b0;
    w_pc_src     = PC_SEQ;
    w_link       = 1'b0;
    case (r_state)
      S_IF: begin
        w_ir_write   = 1'b1;
        w_next_state = S_ID;
      end
      S_ID: begin
        if (!w_legal) begin
          w_next_state = S_HALT;
          w_halt_fault = 1'b1;
        end else if (w_is_halt) begin
          w_next_state = S_HALT;
        end else if (w_is_j) begin
          w_pc_src     = PC_JUMP;
          w_pc_write   = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_IF;
        end else if (w_is_jr) begin
          w_pc_src     = PC_REG;
          w_pc_write   = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_IF;
        end else if (w_is_jal) begin
          w_link       = 1'b1;
          w_reg_write  = 1'b1;
          w_pc_src     = PC_JUMP;
          w_pc_write   = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_IF;
        end else begin
          w_next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (w_is_branch) begin
          w_pc_src     = w_br_taken ? PC_BR : PC_SEQ;
          w_pc_write   = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_IF;
        end else if (w_is_lw || w_is_sw) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        w_mem_read  = w_is_lw;
        w_mem_write = w_is_sw;
        // A ready on the final allowed cycle still completes the access
        if (MemReady) begin
          if (w_is_lw) begin
            w_next_state = S_WB;
          end else begin
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_IF;
          end
        end else if (r_to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
          w_next_state = S_HALT;
          w_halt_fault = 1'b1;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_db         = w_is_lw;
        w_reg_dst    = w_is_rtype;
        w_retire     = 1'b1;
        w_next_state = S_IF;
      end
      S_HALT: ;
      default: begin
        w_next_state = S_HALT;
        w_halt_fault = 1'b1;
      end
    endcase
  end

  // State, retire counter, MEM timeout counter and sticky fault flag
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IF;
      r_retire_cnt <= '0;
      r_to_cnt     <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + COUNT_W'(1);
        r_to_cnt     <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_halt_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign w_alu_hold = (r_state == S_ID) || (r_state == S_EXE) ||
                      (r_state == S_MEM) || (r_state == S_WB);

  // Reset gates every output so no enable survives the falling Reset edge
  assign PCWrite     = Reset & w_pc_write;
  assign IRWrite     = Reset & w_ir_write;
  assign RegWrite    = Reset & w_reg_write;
  assign MemRead     = Reset & w_mem_read;
  assign MemWrite    = Reset & w_mem_write;
  assign DB          = Reset & w_db;
  assign RegDst      = Reset & w_reg_dst;
  assign Link        = Reset & w_link;
  assign PCSrc       = Reset ? w_pc_src : 2'b00;
  assign ALUSrcA     = Reset & w_alu_hold & w_alu_src_a;
  assign ALUSrcB     = Reset & w_alu_hold & w_alu_src_b;
  assign ExtSel      = Reset & w_alu_hold & w_ext_sel;
  assign ALUOp       = (Reset && w_alu_hold) ? w_alu_op : 3'b000;
  assign Halted      = Reset & (r_state == S_HALT);
  assign Fault       = Reset & r_fault;
  assign State       = Reset ? r_state : 3'b000;
  assign RetireCount = r_retire_cnt;

endmodule
